// File: rtl/acc_src_mux4.sv
// 4:1 accumulator source selector with a combinational output and an enabled hold register.
// Optional even-parity output q_par is built only when ACC_SRC_MUX4_PARITY_EN is defined.
module acc_src_mux4 #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_0,
    input  logic [WIDTH-1:0] din_1,
    input  logic [WIDTH-1:0] din_2,
    input  logic [WIDTH-1:0] din_3,
    input  logic [1:0]       sel,
    input  logic             load,
    output logic [WIDTH-1:0] mux_out,
`ifdef ACC_SRC_MUX4_PARITY_EN
    output logic             q_par,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    // Unknown select propagates as all-X rather than silently picking a source.
    always_comb begin
        mux_out = 'x;
        case (sel)
            2'd0:    mux_out = din_0;
            2'd1:    mux_out = din_1;
            2'd2:    mux_out = din_2;
            2'd3:    mux_out = din_3;
            default: mux_out = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else if (load) begin
            q     <= mux_out;
            q_vld <= 1'b1;
        end
    end

`ifdef ACC_SRC_MUX4_PARITY_EN
    assign q_par = ^q;
`endif

endmodule

// File: tb/tb_acc_src_mux4.sv
// Directed bench for acc_src_mux4: mux sweep, load/hold, async reset, reset-vs-load, parity.
// Parity checks are compiled in only when ACC_SRC_MUX4_PARITY_EN is defined.
module tb_acc_src_mux4;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din_0, din_1, din_2, din_3;
    logic [1:0]   sel;
    logic         load;
    logic [W-1:0] mux_out;
    logic [W-1:0] q;
    logic         q_vld;
`ifdef ACC_SRC_MUX4_PARITY_EN
    logic         q_par;
`endif

    int checks = 0;
    int errors = 0;

    acc_src_mux4 #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_0   (din_0),
        .din_1   (din_1),
        .din_2   (din_2),
        .din_3   (din_3),
        .sel     (sel),
        .load    (load),
        .mux_out (mux_out),
`ifdef ACC_SRC_MUX4_PARITY_EN
        .q_par   (q_par),
`endif
        .q       (q),
        .q_vld   (q_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        din_0 = 8'd1; din_1 = 8'd2; din_2 = 8'd3; din_3 = 8'd4;
        sel   = 2'd0;
        load  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_vld", q_vld, 0);
`ifdef ACC_SRC_MUX4_PARITY_EN
        chk("rst_par", q_par, 0);
`endif
        tick();
        rst_n = 1'b1;

        // T1: mux sweep, no load
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("t1_mux_sel%0d", s), mux_out, s + 1);
        end
        tick();
        chk("t1_q_hold", q, 0);
        chk("t1_vld_hold", q_vld, 0);

        // T2: back-to-back loads with changing sel
        sel = 2'd1; load = 1'b1;
        tick();
        chk("t2_q_sel1", q, 2);
        chk("t2_vld", q_vld, 1);
        sel = 2'd3;
        tick();
        chk("t2_q_sel3", q, 4);

        // T3: hold for 3 edges, then load
        sel = 2'd0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t3_hold%0d", i), q, 4);
            chk($sformatf("t3_vld%0d", i), q_vld, 1);
        end
        chk("t3_mux", mux_out, 1);
        load = 1'b1;
        tick();
        chk("t3_q_load", q, 1);

        // Value sampled at the edge wins over a later input change
        din_0 = 8'h5A;
        load  = 1'b0;
        #2;
        chk("late_din_mux", mux_out, 8'h5A);
        chk("late_din_q", q, 1);
        din_0 = 8'd1;

        // Reload 4 before the async reset test
        sel = 2'd3; load = 1'b1;
        tick();
        chk("pre_t4_q", q, 4);
        load = 1'b0;

        // T4: async reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("t4_q", q, 0);
        chk("t4_vld", q_vld, 0);
        sel = 2'd2;
        #1;
        chk("t4_mux", mux_out, 3);

        // T5: reset held over an edge with load=1
        load = 1'b1;
        tick();
        chk("t5_q_rst", q, 0);
        chk("t5_vld_rst", q_vld, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_q", q, 3);
        chk("t5_vld", q_vld, 1);

`ifdef ACC_SRC_MUX4_PARITY_EN
        // T6: parity of loaded values
        din_2 = 8'h03; sel = 2'd2; load = 1'b1;
        tick();
        chk("t6_q03", q, 8'h03);
        chk("t6_par03", q_par, 0);
        din_3 = 8'h07; sel = 2'd3;
        tick();
        chk("t6_q07", q, 8'h07);
        chk("t6_par07", q_par, 1);
`endif
        load = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
